// File: rtl/avr_fetch_pkg.sv
// Shared constants for the AVR fetch stage, program ROM and core top.
package avr_fetch_pkg;

  // Instruction word format
  localparam int unsigned INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  // Defaults shared by the program counter, ROM and core top
  localparam int unsigned DEFAULT_PC_WIDTH = 4;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  // Primary opcode field, consumed by decode
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 10;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef logic [INSTR_W-1:0] instr_t;

  // Extract the primary opcode field from an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input instr_t word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {word, pc} queue between the ROM return path and decode.
// Entry 0 is always the head; flush empties the queue and beats push/pop.
module fetch_fifo
  import avr_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DEFAULT_PC_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  instr_t              push_word,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic                pop,
  output instr_t              head_word,
  output logic [PC_WIDTH-1:0] head_pc,
  output logic [1:0]          count
);

  instr_t              word0_q, word0_d, word1_q, word1_d;
  logic [PC_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]          count_q, count_d;

  // Next-state: shift on pop, fill the first free slot on push
  always_comb begin
    word0_d = word0_q;
    word1_d = word1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            word0_d = push_word;
            pc0_d   = push_pc;
          end else begin
            word1_d = push_word;
            pc1_d   = push_pc;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          word0_d = word1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count holds; the new word lands behind whatever survives the pop
          if (count_q == 2'd1) begin
            word0_d = push_word;
            pc0_d   = push_pc;
          end else begin
            word0_d = word1_q;
            pc0_d   = pc1_q;
            word1_d = push_word;
            pc1_d   = push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word0_q <= NOP_WORD;
      word1_q <= NOP_WORD;
      pc0_q   <= '0;
      pc1_q   <= '0;
      count_q <= 2'd0;
    end else begin
      word0_q <= word0_d;
      word1_q <= word1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      count_q <= count_d;
    end
  end

  // Head is presented straight from registers
  always_comb begin
    head_word = word0_q;
    head_pc   = pc0_q;
    count     = count_q;
  end

endmodule

// File: rtl/avr_fetch.sv
// AVR instruction fetch: owns the PC, drives a 1-cycle synchronous ROM,
// queues returned words and hands them to decode over valid/ready.
module avr_fetch
  import avr_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [PC_WIDTH-1:0] ResetPc = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PcOne   = PC_WIDTH'(1);

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic                deq, issue, push;
  logic [2:0]          occupancy;
  logic [1:0]          fifo_count;
  instr_t              head_word;
  logic [PC_WIDTH-1:0] head_pc;

  fetch_fifo #(
    .PC_WIDTH(PC_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_word(rom_data),
    .push_pc  (inflight_pc_q),
    .pop      (deq),
    .head_word(head_word),
    .head_pc  (head_pc),
    .count    (fifo_count)
  );

  // Handshake and issue control; occupancy counts slots already promised
  always_comb begin
    deq       = (fifo_count != 2'd0) && instr_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, deq};
    issue     = !redirect_valid && (occupancy < 3'd2);
    // A redirect discards the word returning this cycle
    push      = inflight_q && !redirect_valid;
  end

  // Next PC and in-flight tracking; a redirect suppresses issue for one cycle
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PcOne;
    end
  end

  // PC and in-flight state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Outputs; an empty queue shows a NOP at pc 0
  always_comb begin
    rom_addr    = fetch_pc_q;
    pc          = fetch_pc_q;
    instr_valid = (fifo_count != 2'd0);
    instruction = instr_valid ? head_word : NOP_WORD;
    instr_pc    = instr_valid ? head_pc : '0;
  end

endmodule

// File: tb/tb_avr_fetch.sv
// Directed bench for avr_fetch with a 16-word synchronous ROM model.
module tb_avr_fetch;

  logic        clk;
  logic        reset;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [3:0]  instr_pc;
  logic [3:0]  pc;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] rom [16];

  avr_fetch #(
    .PC_WIDTH(4),
    .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .pc            (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
  end

  // Synchronous ROM: registers the address, data valid the next cycle
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;

    // Held in reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", 32'(instruction), 32'h0000);
    check_eq("rst_ipc", 32'(instr_pc), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_addr", 32'(rom_addr), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // Fill: valid appears after the second edge
    tick();
    check_eq("fill_valid", 32'(instr_valid), 32'd0);
    check_eq("fill_pc", 32'(pc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("stream_valid", 32'(instr_valid), 32'd1);
      check_eq("stream_instr", 32'(instruction), 32'h1000 + 32'(i));
      check_eq("stream_ipc", 32'(instr_pc), 32'(i));
      check_eq("stream_pc", 32'(pc), 32'(i + 2));
    end

    // Backpressure with head at pc 3
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", 32'(instr_valid), 32'd1);
      check_eq("bp_instr", 32'(instruction), 32'h1003);
      check_eq("bp_ipc", 32'(instr_pc), 32'd3);
      check_eq("bp_pc", 32'(pc), 32'd5);
      check_eq("bp_count", 32'(dut.fifo_count), 32'd2);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("resume_instr", 32'(instruction), 32'h1004 + 32'(i));
      check_eq("resume_ipc", 32'(instr_pc), 32'(4 + i));
      check_eq("resume_pc", 32'(pc), 32'(6 + i));
    end

    // Refill, then redirect to 9 with the queue full
    instr_ready = 1'b0;
    tick();
    check_eq("full_count", 32'(dut.fifo_count), 32'd2);
    check_eq("full_instr", 32'(instruction), 32'h1006);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 4'd9;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    check_eq("redir_valid1", 32'(instr_valid), 32'd0);
    check_eq("redir_addr", 32'(rom_addr), 32'd9);
    tick();
    check_eq("redir_valid2", 32'(instr_valid), 32'd0);
    check_eq("redir_nop", 32'(instruction), 32'h0000);

    // Redirect target arrives, then stream through the wrap at 15
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("wrap_valid", 32'(instr_valid), 32'd1);
      check_eq("wrap_ipc", 32'(instr_pc), 32'((9 + i) % 16));
      check_eq("wrap_instr", 32'(instruction), 32'h1000 + 32'((9 + i) % 16));
      check_eq("wrap_addr", 32'(rom_addr), 32'((11 + i) % 16));
    end

    // Back-to-back redirects: 4 then 7, only 7 survives
    redirect_valid = 1'b1;
    redirect_pc    = 4'd4;
    tick();
    check_eq("b2b_valid0", 32'(instr_valid), 32'd0);
    check_eq("b2b_pc0", 32'(pc), 32'd4);
    redirect_pc = 4'd7;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    check_eq("b2b_valid1", 32'(instr_valid), 32'd0);
    check_eq("b2b_pc1", 32'(pc), 32'd7);
    tick();
    check_eq("b2b_valid2", 32'(instr_valid), 32'd0);
    check_eq("b2b_pc2", 32'(pc), 32'd8);
    tick();
    check_eq("b2b_valid3", 32'(instr_valid), 32'd1);
    check_eq("b2b_ipc3", 32'(instr_pc), 32'd7);
    check_eq("b2b_instr3", 32'(instruction), 32'h1007);
    tick();
    check_eq("b2b_ipc4", 32'(instr_pc), 32'd8);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(instr_valid), 32'd0);
    check_eq("arst_instr", 32'(instruction), 32'h0000);
    check_eq("arst_ipc", 32'(instr_pc), 32'd0);
    check_eq("arst_pc", 32'(pc), 32'd0);
    check_eq("arst_count", 32'(dut.fifo_count), 32'd0);
    tick();
    check_eq("arst_hold", 32'(instr_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_eq("rel_valid", 32'(instr_valid), 32'd0);
    check_eq("rel_pc", 32'(pc), 32'd1);
    tick();
    check_eq("rel_valid2", 32'(instr_valid), 32'd1);
    check_eq("rel_instr", 32'(instruction), 32'h1000);
    check_eq("rel_ipc", 32'(instr_pc), 32'd0);
    tick();
    check_eq("rel_ipc2", 32'(instr_pc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avr_fetch.md
Name: avr_fetch

Overview:
- Instruction fetch stage directly upstream of the AVR decode/execute core.
- Owns the program counter and drives a synchronous program ROM (1-cycle read latency).
- Buffers returned words in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from the core and squashes wrong-path fetches.

Parameters:
- PC_WIDTH, 4, program counter / ROM address width in words.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; block held in reset while reset=0.
- rom_addr  out  PC_WIDTH  ROM word address; ROM registers it on the clk edge.
- rom_data  in  16  ROM word for the address presented in the previous cycle.
- redirect_valid  in  1  core requests fetch restart this cycle.
- redirect_pc  in  PC_WIDTH  restart target.
- instr_valid  out  1  queue head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instruction  out  16  head instruction word; 16'h0000 (NOP) when instr_valid=0.
- instr_pc  out  PC_WIDTH  address of the head instruction; 0 when invalid.
- pc  out  PC_WIDTH  current fetch_pc, for debug/LED display.

Behaviour:
- State: fetch_pc, inflight (1 bit), inflight_pc, 2-entry FIFO of {word, pc}, count 0..2.
- rom_addr = fetch_pc, driven combinationally from the register.
- deq = instr_valid & instr_ready. instr_valid = (count != 0). The head is presented from registers, with no combinational path from rom_data.
- Issue rule: issue = !redirect_valid & (count + inflight - deq < 2).
  - On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 1 (mod 2^PC_WIDTH; 15 wraps to 0 at the default width).
  - Otherwise inflight <= 0 and fetch_pc holds.
- Return: when inflight=1 and !redirect_valid, push {rom_data, inflight_pc} at the end of the cycle. The issue rule guarantees the push never overflows.
- Simultaneous push and deq: count holds and the entries shift correctly.
- Redirect (cycle N):
  - A deq in cycle N still completes.
  - The FIFO is cleared and the inflight return is discarded.
  - fetch_pc <= redirect_pc, and nothing is issued in cycle N.
  - N+1: rom_addr=redirect_pc, issued. N+2: data returns and is pushed. N+3: instr_valid=1 with instr_pc=redirect_pc. Redirect-to-valid latency is 3 cycles.
- Back-to-back redirects: the last one wins; each restarts the 3-cycle latency.
- Throughput: with instr_ready held at 1, one instruction per cycle sustained after a 2-cycle fill.
- Backpressure: with instr_ready=0 the queue fills to 2 and issue stops. fetch_pc stops at head_pc+2. No word is lost or duplicated.
- instruction and instr_pc stay stable while instr_valid=1 and instr_ready=0.
- Reset (async, any time, including mid-burst):
  - fetch_pc=RESET_PC, inflight=0, count=0.
  - instr_valid=0, instruction=0, instr_pc=0, pc=RESET_PC.
  - First cycle after release: rom_addr=RESET_PC issued. instr_valid=1 two cycles after release.
- rom_data is ignored whenever inflight=0.

Decomposition:
- Shared package holds:
  - INSTR_W=16.
  - NOP_WORD=16'h0000.
  - Default PC_WIDTH and RESET_PC, shared with the program counter, ROM, and core top.
  - Opcode field positions [15:10], for later use by decode.
- One sub-module: fetch_fifo, a 2-entry {word, pc} queue with push/pop/flush, count, and async active-low clear. The PC, issue and redirect logic stays in avr_fetch.

Test Plan:
- Reset release, ROM[i]=16'h1000+i, ready=1 -> instr_valid rises on cycle 2; instructions 1000, 1001, 1002… with instr_pc 0, 1, 2 on consecutive cycles.
- ready=0 for 5 cycles mid-stream at head pc=3 -> count=2, pc=5, head stays 1003. Then ready=1 -> 1003, 1004, 1005 with no gaps or duplicates.
- redirect_valid=1, redirect_pc=9, while the queue is full and ready=1 -> head consumed that cycle; instr_valid=0 for 2 cycles; cycle N+3 instr_pc=9, instruction=ROM[9]; no stale 1004/1005 ever appears.
- Run through pc=15 with ready=1 -> instr_pc sequence 14, 15, 0, 1 and rom_addr wraps.
- redirect on cycle N (pc 4) then on N+1 (pc 7) -> only pc 7 onward is delivered, first valid at N+4.
- Assert reset=0 asynchronously mid-burst (between edges) -> instr_valid and count clear immediately; after release, refetch from RESET_PC with 2-cycle latency.
